// File: rtl/btn_event_arbiter.sv
// Push-button front end: per-button synchroniser, debounce, toggle and hold timing,
// with one shared valid/ready event channel granted round-robin among the buttons.
module btn_event_arbiter #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CNT = 20,
    parameter int HOLD_CNT     = 1000,
    parameter int ID_W         = 2
) (
    input  logic             CLK_1KHZ,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_STABLE,
    output logic [N_BTN-1:0] BTN_TOGGLE,
    output logic             EVT_VALID,
    output logic [ID_W-1:0]  EVT_ID,
    output logic             EVT_LONG,
    input  logic             EVT_READY,
    output logic             OVERRUN
);

    localparam int DB_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam int HOLD_W = $clog2(HOLD_CNT + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t            state;
    logic [N_BTN-1:0]  sync_q1;
    logic [N_BTN-1:0]  sync_q2;
    logic [DB_W-1:0]   db_cnt   [N_BTN];
    logic [HOLD_W-1:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0]  press_pend;
    logic [N_BTN-1:0]  long_pend;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  fall;
    logic [N_BTN-1:0]  long_hit;
    logic [N_BTN-1:0]  press_clr;
    logic [N_BTN-1:0]  long_clr;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              grant_long;
    logic              accept;

    // A debounced edge is the cycle the counter expires with the synced level still different.
    always_comb begin
        rise     = '0;
        fall     = '0;
        long_hit = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync_q2[i] != BTN_STABLE[i] && db_cnt[i] == DB_LAST) begin
                rise[i] = sync_q2[i];
                fall[i] = ~sync_q2[i];
            end
            long_hit[i] = BTN_STABLE[i] && !fall[i] && (hold_cnt[i] != HOLD_LAST)
                          && (hold_cnt[i] + HOLD_W'(1) == HOLD_LAST);
        end
    end

    always_comb begin
        accept    = (state == OFFER) && EVT_READY;
        press_clr = '0;
        long_clr  = '0;
        if (accept) begin
            if (EVT_LONG)
                long_clr[EVT_ID] = 1'b1;
            else
                press_clr[EVT_ID] = 1'b1;
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_long  = 1'b0;
        cand        = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N_BTN);
            if (!grant_found && (press_pend[cand] || long_pend[cand])) begin
                grant_found = 1'b1;
                grant_id    = cand;
                grant_long  = !press_pend[cand];
            end
        end
    end

    always_ff @(posedge CLK_1KHZ) begin
        if (RST) begin
            sync_q1    <= '0;
            sync_q2    <= '0;
            BTN_STABLE <= '0;
            BTN_TOGGLE <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= BTN_RAW;
            sync_q2 <= sync_q1;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_q2[i] == BTN_STABLE[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    BTN_STABLE[i] <= sync_q2[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end

                if (rise[i]) begin
                    BTN_TOGGLE[i] <= ~BTN_TOGGLE[i];
                    hold_cnt[i]   <= '0;
                end else if (fall[i] || !BTN_STABLE[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_LAST) begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                end
            end
        end
    end

    // A new set beats a same-cycle acceptance clear; only a set on a still-pending bit is lost.
    always_ff @(posedge CLK_1KHZ) begin
        if (RST) begin
            press_pend <= '0;
            long_pend  <= '0;
            OVERRUN    <= 1'b0;
        end else begin
            press_pend <= (press_pend & ~press_clr) | rise;
            long_pend  <= (long_pend & ~long_clr) | long_hit;
            if (|((rise & press_pend & ~press_clr) | (long_hit & long_pend & ~long_clr)))
                OVERRUN <= 1'b1;
        end
    end

    always_ff @(posedge CLK_1KHZ) begin
        if (RST) begin
            state      <= IDLE;
            EVT_VALID  <= 1'b0;
            EVT_ID     <= '0;
            EVT_LONG   <= 1'b0;
            last_grant <= ID_W'(N_BTN - 1);
        end else if (state == IDLE) begin
            if (grant_found) begin
                EVT_ID    <= grant_id;
                EVT_LONG  <= grant_long;
                EVT_VALID <= 1'b1;
                state     <= OFFER;
            end
        end else if (EVT_READY) begin
            EVT_VALID  <= 1'b0;
            last_grant <= EVT_ID;
            state      <= IDLE;
        end
    end

endmodule
